// File: rtl/f_delay_prog_if.sv
// Sample bus for f_delay_prog: input sample (valid + multi-channel data)
// and the delayed output sample.
//   i_valid / i_data : sample entering the delay line (driven by master)
//   o_valid / o_data : delayed sample leaving the line (driven by slave)
interface f_delay_prog_if #(
  parameter int unsigned pSIZE = 8,
  parameter int unsigned pCH   = 4
);
  logic                  i_valid;
  logic [pCH*pSIZE-1:0]  i_data;
  logic                  o_valid;
  logic [pCH*pSIZE-1:0]  o_data;

  modport master (output i_valid, output i_data, input  o_valid, input  o_data);
  modport slave  (input  i_valid, input  i_data, output o_valid, output o_data);
endinterface

// File: rtl/f_delay_prog.sv
// Multi-channel delay line with a runtime-programmable delay (0..pMAX_DELAY),
// per-sample valid tracking, clock-enable stall and flush. A delay load or a
// flush purges in-flight valids so stale, mis-aligned data is never emitted.
// Ports:
//   i_clk       rising-edge clock
//   i_rst       synchronous active-high reset
//   i_en        clock enable; 0 stalls the whole line
//   i_flush     pulse; clears in-flight valids
//   i_dly_load  pulse; loads i_dly (clamped) as the active delay
//   i_dly       requested delay in enabled cycles
//   bus         sample in (i_valid/i_data) and delayed sample out (o_valid/o_data)
//   o_dly       active delay
//   o_fill      high while the line refills after a purge
//   o_cfg_err   one-cycle pulse when a requested delay was clamped
module f_delay_prog #(
  parameter int unsigned pSIZE       = 8,
  parameter int unsigned pCH         = 4,
  parameter int unsigned pMAX_DELAY  = 16,
  parameter int unsigned pINIT_DELAY = 2,
  parameter int unsigned pDW         = $clog2(pMAX_DELAY + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_en,
  input  logic            i_flush,
  input  logic            i_dly_load,
  input  logic [pDW-1:0]  i_dly,
  f_delay_prog_if.slave   bus,
  output logic [pDW-1:0]  o_dly,
  output logic            o_fill,
  output logic            o_cfg_err
);

  localparam int unsigned DW = pCH * pSIZE;

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] data;
  } stage_t;

  typedef enum logic {RUN, FILL} state_t;

  stage_t         r_stage [pMAX_DELAY];
  logic [pDW-1:0] r_dly;
  logic [pDW-1:0] r_cnt;
  logic           r_cfg_err;
  state_t         r_state;

  state_t         state_nxt_c;
  logic [pDW-1:0] cnt_nxt_c;
  logic [pDW-1:0] dly_req_c;
  logic [pDW-1:0] dly_nxt_c;
  logic           over_c;
  logic           purge_c;
  stage_t         tap_c;

  // Clamp the requested delay; the delay seen by the fill logic is the one
  // that will be active after this edge.
  assign over_c    = (i_dly > pDW'(pMAX_DELAY));
  assign dly_req_c = over_c ? pDW'(pMAX_DELAY) : i_dly;
  assign dly_nxt_c = i_dly_load ? dly_req_c : r_dly;
  assign purge_c   = i_dly_load | i_flush;

  // Shift register; purge clears valids but keeps data bits untouched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < int'(pMAX_DELAY); k++) r_stage[k] <= '0;
    end else begin
      if (i_en) begin
        r_stage[0] <= {bus.i_valid, bus.i_data};
        for (int k = 1; k < int'(pMAX_DELAY); k++) r_stage[k] <= r_stage[k-1];
      end
      if (purge_c) begin
        for (int k = 1; k < int'(pMAX_DELAY); k++) r_stage[k].valid <= 1'b0;
        // With the line enabled the current input is fresh and keeps its valid.
        if (!i_en) r_stage[0].valid <= 1'b0;
      end
    end
  end

  // Delay and clamp-error registers; loads ignore i_en.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dly     <= pDW'(pINIT_DELAY);
      r_cfg_err <= 1'b0;
    end else begin
      r_dly     <= dly_nxt_c;
      r_cfg_err <= i_dly_load & over_c;
    end
  end

  // Fill state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= state_nxt_c;
      r_cnt   <= cnt_nxt_c;
    end
  end

  // Fill next-state: a purge (re)starts the fill with the latest delay.
  always_comb begin
    state_nxt_c = r_state;
    cnt_nxt_c   = r_cnt;
    if (purge_c) begin
      if (dly_nxt_c > pDW'(1)) begin
        state_nxt_c = FILL;
        cnt_nxt_c   = pDW'(1);
      end else begin
        state_nxt_c = RUN;
        cnt_nxt_c   = '0;
      end
    end else begin
      unique case (r_state)
        RUN:  ;
        FILL: begin
          if (i_en) begin
            cnt_nxt_c = r_cnt + pDW'(1);
            if (r_cnt == r_dly - pDW'(1)) state_nxt_c = RUN;
          end
        end
        default: state_nxt_c = RUN;
      endcase
    end
  end

  // Output tap: stage[r_dly-1]; held naturally while stalled.
  always_comb begin
    tap_c = '0;
    for (int k = 0; k < int'(pMAX_DELAY); k++) begin
      if (r_dly == pDW'(k + 1)) tap_c = r_stage[k];
    end
  end

  // Delay 0 is a combinational bypass.
  assign bus.o_data  = (r_dly == '0) ? bus.i_data : tap_c.data;
  assign bus.o_valid = (r_dly == '0) ? (bus.i_valid & i_en) : tap_c.valid;
  assign o_dly       = r_dly;
  assign o_fill      = (r_state == FILL);
  assign o_cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_f_delay_prog.sv
// Directed self-checking bench for f_delay_prog (default parameters).
module tb_f_delay_prog;

  localparam int unsigned SZ    = 8;
  localparam int unsigned CH    = 4;
  localparam int unsigned MAXD  = 16;
  localparam int unsigned INITD = 2;
  localparam int unsigned DDW   = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           flush;
  logic           dly_load;
  logic [DDW-1:0] dly;
  logic [DDW-1:0] o_dly;
  logic           o_fill;
  logic           o_cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  f_delay_prog_if #(.pSIZE(SZ), .pCH(CH)) bus ();

  f_delay_prog #(
    .pSIZE(SZ), .pCH(CH), .pMAX_DELAY(MAXD), .pINIT_DELAY(INITD), .pDW(DDW)
  ) u_dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_flush(flush),
    .i_dly_load(dly_load), .i_dly(dly), .bus(bus),
    .o_dly(o_dly), .o_fill(o_fill), .o_cfg_err(o_cfg_err)
  );

  function automatic logic [31:0] dval(input int i);
    return 32'h04030201 + 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    bus.i_valid = v;
    bus.i_data  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0; dly_load = 1'b0; dly = '0;
    drive(1'b0, 32'h0);
    tick(); tick();
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_data",  bus.o_data,       32'd0);
    chk("rst_fill",  32'(o_fill),      32'd0);
    chk("rst_cfgerr",32'(o_cfg_err),   32'd0);
    chk("rst_dly",   32'(o_dly),       32'd2);
    rst = 1'b0;

    // Stream with the reset delay of 2.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, dval(i));
      tick();
      chk("s1_fill", 32'(o_fill), 32'd0);
      if (i + 1 < 2) chk("s1_valid0", 32'(bus.o_valid), 32'd0);
      else begin
        chk("s1_valid", 32'(bus.o_valid), 32'd1);
        chk("s1_data",  bus.o_data, dval(i - 1));
      end
    end

    // Load delay 5 at cycle 10 while streaming.
    drive(1'b1, dval(10)); dly = 5'd5; dly_load = 1'b1;
    tick();
    dly_load = 1'b0;
    chk("l5_fill",   32'(o_fill),    32'd1);
    chk("l5_valid",  32'(bus.o_valid), 32'd0);
    chk("l5_dly",    32'(o_dly),     32'd5);
    chk("l5_cfgerr", 32'(o_cfg_err), 32'd0);
    for (int i = 11; i < 20; i++) begin
      drive(1'b1, dval(i));
      tick();
      if (i + 1 < 15) begin
        chk("l5_fill_hi", 32'(o_fill), 32'd1);
        chk("l5_valid_lo", 32'(bus.o_valid), 32'd0);
      end else begin
        chk("l5_fill_lo", 32'(o_fill), 32'd0);
        chk("l5_valid_hi", 32'(bus.o_valid), 32'd1);
        chk("l5_data", bus.o_data, dval(i + 1 - 5));
      end
    end

    // Delay 3 with a 4-cycle stall mid-stream.
    drive(1'b1, dval(20)); dly = 5'd3; dly_load = 1'b1;
    tick();
    dly_load = 1'b0;
    chk("l3_fill", 32'(o_fill), 32'd1);
    for (int i = 21; i < 25; i++) begin
      drive(1'b1, dval(i));
      tick();
      if (i + 1 < 23) chk("l3_valid_lo", 32'(bus.o_valid), 32'd0);
      else chk("l3_data", bus.o_data, dval(i + 1 - 3));
    end
    en = 1'b0;
    drive(1'b1, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stall_data",  bus.o_data, dval(22));
      chk("stall_valid", 32'(bus.o_valid), 32'd1);
    end
    en = 1'b1;
    for (int i = 25; i < 29; i++) begin
      drive(1'b1, dval(i));
      tick();
      chk("resume_valid", 32'(bus.o_valid), 32'd1);
      chk("resume_data",  bus.o_data, dval(i - 2));
    end

    // Delay 0: combinational bypass.
    drive(1'b1, dval(29)); dly = 5'd0; dly_load = 1'b1;
    tick();
    dly_load = 1'b0;
    chk("l0_dly",  32'(o_dly),  32'd0);
    chk("l0_fill", 32'(o_fill), 32'd0);
    drive(1'b1, 32'hA5A55A5A);
    #1;
    chk("byp_data",  bus.o_data, 32'hA5A55A5A);
    chk("byp_valid", 32'(bus.o_valid), 32'd1);
    en = 1'b0;
    #1;
    chk("byp_en0_valid", 32'(bus.o_valid), 32'd0);
    chk("byp_en0_data",  bus.o_data, 32'hA5A55A5A);
    en = 1'b1;
    bus.i_valid = 1'b0;
    #1;
    chk("byp_v0_valid", 32'(bus.o_valid), 32'd0);

    // Out-of-range load is clamped and flagged for one cycle.
    drive(1'b0, 32'h0); dly = 5'd20; dly_load = 1'b1;
    tick();
    dly_load = 1'b0;
    chk("clamp_dly",    32'(o_dly),     32'd16);
    chk("clamp_err",    32'(o_cfg_err), 32'd1);
    chk("clamp_fill",   32'(o_fill),    32'd1);
    tick();
    chk("clamp_err_end", 32'(o_cfg_err), 32'd0);
    chk("clamp_dly2",    32'(o_dly),     32'd16);

    // Flush together with a load of 4: one purge, latest delay.
    flush = 1'b1; dly_load = 1'b1; dly = 5'd4;
    drive(1'b1, 32'h11111111);
    tick();
    flush = 1'b0; dly_load = 1'b0;
    drive(1'b0, 32'h0);
    chk("fl_dly",    32'(o_dly),     32'd4);
    chk("fl_fill",   32'(o_fill),    32'd1);
    chk("fl_cfgerr", 32'(o_cfg_err), 32'd0);
    chk("fl_valid",  32'(bus.o_valid), 32'd0);
    tick(); tick();
    chk("fl_valid3", 32'(bus.o_valid), 32'd0);
    chk("fl_fill3",  32'(o_fill),    32'd1);
    tick();
    chk("fl_valid4", 32'(bus.o_valid), 32'd1);
    chk("fl_data4",  bus.o_data,     32'h11111111);
    chk("fl_fill4",  32'(o_fill),    32'd0);

    // Flush while stalled also clears the stage-0 valid.
    drive(1'b1, 32'h22222222);
    tick();
    en = 1'b0; flush = 1'b1;
    drive(1'b0, 32'h0);
    tick();
    flush = 1'b0; en = 1'b1;
    chk("fls_fill", 32'(o_fill), 32'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fls_valid", 32'(bus.o_valid), 32'd0);
    end

    // Reset during FILL with samples in flight.
    dly = 5'd6; dly_load = 1'b1;
    drive(1'b1, 32'h33333333);
    tick();
    dly_load = 1'b0;
    chk("rf_fill", 32'(o_fill), 32'd1);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h44444444);
      tick();
    end
    rst = 1'b1;
    drive(1'b1, 32'h55555555);
    tick();
    chk("rf_valid",  32'(bus.o_valid), 32'd0);
    chk("rf_fill0",  32'(o_fill),    32'd0);
    chk("rf_dly",    32'(o_dly),     32'd2);
    chk("rf_data",   bus.o_data,     32'd0);
    chk("rf_cfgerr", 32'(o_cfg_err), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'hA0000000 + 32'(i));
      tick();
      if (i + 1 < 2) chk("rs_valid0", 32'(bus.o_valid), 32'd0);
      else begin
        chk("rs_valid", 32'(bus.o_valid), 32'd1);
        chk("rs_data",  bus.o_data, 32'hA0000000 + 32'(i - 1));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/f_delay_prog.md
Name: f_delay_prog

Overview:
- Multi-channel, runtime-programmable delay line with per-sample valid tracking, clock-enable stall and flush.
- Successor to the fixed-depth delay register chain.
- Used in DMA datapaths to align data/control lanes whose latency is configured by software, not fixed at build time.
- Delay is selectable 0..pMAX_DELAY. A delay change or flush purges stale samples, so no mis-aligned data is ever emitted.

Parameters:
- pSIZE, 8, width of one channel in bits.
- pCH, 4, number of channels; all channels share one delay and one valid.
- pMAX_DELAY, 16, maximum delay in enabled cycles; must be >= 1.
- pINIT_DELAY, 2, delay after reset; must be <= pMAX_DELAY.
- pDW, $clog2(pMAX_DELAY+1), width of the delay field (derived).

Ports:
- Interface: one clock; reset is synchronous and active-high.
- i_clk  input  1  clock; all logic rising-edge.
- i_rst  input  1  synchronous active-high reset.
- i_en  input  1  clock enable; 0 = whole line stalls and holds.
- i_flush  input  1  single-cycle pulse; clears all in-flight valids.
- i_dly_load  input  1  single-cycle pulse; loads i_dly as the new delay.
- i_dly  input  pDW  requested delay in enabled cycles.
- i_valid  input  1  input sample valid.
- i_data  input  pCH*pSIZE  input sample; channel c at [pSIZE*(c+1)-1 : pSIZE*c].
- o_valid  output  1  output sample valid.
- o_data  output  pCH*pSIZE  delayed sample.
- o_dly  output  pDW  currently active delay.
- o_fill  output  1  high while the line refills after a load or flush.
- o_cfg_err  output  1  one-cycle pulse: requested delay was clamped.

Behaviour:
- Storage: pMAX_DELAY stages, each {valid, pCH*pSIZE data}.
  - When i_en=1: stage0 <= {i_valid, i_data} and stage k <= stage k-1.
  - When i_en=0: no stage changes.
- Delay register r_dly (drives o_dly):
  - On i_dly_load, r_dly <= min(i_dly, pMAX_DELAY).
  - If i_dly > pMAX_DELAY: o_cfg_err=1 for the next cycle only.
  - Loads apply regardless of i_en.
- Output tap:
  - r_dly >= 1: o_data = stage[r_dly-1].data, o_valid = stage[r_dly-1].valid.
  - r_dly = 0: combinational bypass; o_data = i_data, o_valid = i_valid & i_en.
  - o_data is held while i_en=0; o_valid is likewise held, except in bypass.
- Latency: a sample accepted at cycle T (i_en=1) appears at cycle T+r_dly, counting only cycles with i_en=1.
- Purge (i_dly_load or i_flush in cycle T):
  - All stage valid bits k>=1 are cleared at the next edge.
  - If i_en=1, the cycle-T input is still written to stage0 with its own valid.
  - If i_en=0, stage0 valid is also cleared.
  - Data bits are not cleared.
- Simultaneous load+flush: the load is applied; a single purge occurs.
- Fill state machine, states RUN and FILL:
  - Reset -> RUN.
  - Purge with new delay d >= 2 -> FILL, and fill counter r_cnt <= 1.
  - In FILL, each enabled cycle increments r_cnt. When r_cnt == d-1 on an enabled cycle -> RUN.
  - Purge with d <= 1 -> RUN directly.
  - A purge while in FILL restarts the fill with the latest d.
  - o_fill = (state == FILL). o_valid is 0 throughout FILL by construction.
- Reset (from any state, mid-stream included):
  - All stage valid and data = 0; r_dly = pINIT_DELAY; r_cnt = 0; state RUN.
  - Outputs then: o_valid = 0, o_data = 0, o_fill = 0, o_cfg_err = 0, o_dly = pINIT_DELAY.
  - Exception: if pINIT_DELAY = 0, o_data/o_valid follow the bypass rule immediately.
- Wrap and boundary:
  - r_dly = pMAX_DELAY taps the last stage.
  - Data shifted out of the last stage is discarded.
  - No backpressure; the block never drops an accepted sample except by purge.

Test Plan:
- Reset, pINIT_DELAY=2; drive i_valid=1, i_data=0x04030201 at cycle 0, then incrementing values with i_en=1 → 0x04030201 appears at o_data with o_valid=1 at cycle 2; o_fill=0 throughout.
- Load i_dly=5 at cycle 10 while streaming → o_valid=0 and o_fill=1 for cycles 11..14; the sample from cycle 10 emerges at cycle 15; no sample older than cycle 10 is ever emitted.
- Delay 3, stream, then hold i_en=0 for 4 cycles mid-stream → o_data/o_valid frozen; after re-enable the sequence resumes with no gap or duplicate; latency is 3 enabled cycles.
- Load i_dly=0 → o_data tracks i_data in the same cycle; i_en=0 forces o_valid=0.
- Load i_dly=20 (pMAX_DELAY=16) → o_dly=16, o_cfg_err pulses exactly 1 cycle; flush asserted in the same cycle as a second load → single purge, latest delay taken.
- Assert i_rst during FILL with samples in flight → next cycle o_valid=0, o_fill=0, o_dly=pINIT_DELAY; the subsequent stream obeys pINIT_DELAY latency.
